// File: rtl/buffer_pkg.sv
// Shared types and defaults for the buffer_lru family of blocks.
// Holds slot geometry defaults, the dump FSM state type and the slot index type.
package buffer_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_BUF_SIZE = 8;
    localparam int IDX_W        = $clog2(DEF_BUF_SIZE);

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } dump_state_t;

endpackage

// File: rtl/buffer_lru_dump.sv
// Snapshots buffer_lru contents on start_i and streams slots out over valid/ready.
// Ports:
//   clk_i, rst_i (async, active-low)      clock / reset
//   start_i                               dump request, sampled only in IDLE
//   buf_array_i                           parallel slot contents
//   valid_o/ready_i                       beat handshake
//   data_o, idx_o, last_o                 beat payload (zero when valid_o=0)
//   busy_o, done_o, count_o               dump status
module buffer_lru_dump
    import buffer_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int BUF_SIZE   = DEF_BUF_SIZE,
    parameter int SKIP_EMPTY = 1,
    localparam int IW        = $clog2(BUF_SIZE),
    localparam int CW        = $clog2(BUF_SIZE + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic [BUF_SIZE-1:0][WIDTH-1:0]   buf_array_i,
    output logic                             busy_o,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [WIDTH-1:0]                 data_o,
    output logic [IW-1:0]                    idx_o,
    output logic                             last_o,
    output logic                             done_o,
    output logic [CW-1:0]                    count_o
);

    dump_state_t                     r_state;
    logic [BUF_SIZE-1:0][WIDTH-1:0]  r_snap;
    logic [IW-1:0]                   r_ptr;
    logic [CW-1:0]                   r_count;

    logic                            w_out;
    logic                            w_last;
    logic                            w_cur_emit;

    function automatic logic f_emitable(input logic [WIDTH-1:0] v);
        return (SKIP_EMPTY != 0) ? (|v) : 1'b1;
    endfunction

    // True when some slot strictly above p would still be emitted.
    function automatic logic f_emit_above(
        input logic [BUF_SIZE-1:0][WIDTH-1:0] s,
        input logic [IW-1:0]                  p
    );
        logic r;
        r = 1'b0;
        for (int i = 0; i < BUF_SIZE; i++) begin
            if (i > int'(p) && f_emitable(s[i])) begin
                r = 1'b1;
            end
        end
        return r;
    endfunction

    assign w_out      = (r_state == OUT);
    assign w_cur_emit = f_emitable(r_snap[r_ptr]);
    assign w_last     = ~f_emit_above(r_snap, r_ptr);

    assign valid_o = w_out;
    assign data_o  = w_out ? r_snap[r_ptr] : '0;
    assign idx_o   = w_out ? r_ptr : '0;
    assign last_o  = w_out & w_last;
    assign busy_o  = (r_state != IDLE);
    assign done_o  = (r_state == DONE);
    assign count_o = r_count;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_snap  <= '0;
            r_ptr   <= '0;
            r_count <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_snap  <= buf_array_i;
                        r_ptr   <= '0;
                        r_count <= '0;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_cur_emit) begin
                        r_state <= OUT;
                    end else if (r_ptr == IW'(BUF_SIZE - 1)) begin
                        r_state <= DONE;
                    end else begin
                        r_ptr <= r_ptr + IW'(1);
                    end
                end
                OUT: begin
                    if (ready_i) begin
                        r_count <= r_count + CW'(1);
                        if (w_last) begin
                            r_state <= DONE;
                        end else begin
                            r_ptr   <= r_ptr + IW'(1);
                            r_state <= SCAN;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_lru_dump.sv
// Directed bench for buffer_lru_dump with a beat scoreboard per instance.
// Instance dut skips empty slots; dut0 emits every slot.
module tb_buffer_lru_dump;

    typedef struct packed {
        logic [15:0] d;
        logic [2:0]  i;
        logic        l;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, start0, ready;
    logic [7:0][15:0]  arr;

    logic              busy, valid, last, done;
    logic [15:0]       data;
    logic [2:0]        idx;
    logic [3:0]        count;

    logic              busy0, valid0, last0, done0;
    logic [15:0]       data0;
    logic [2:0]        idx0;
    logic [3:0]        count0;

    int    n_tests  = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    n_done   = 0;
    int    n_done0  = 0;
    int    last_cyc = 0;
    int    n_acc2   = 0;
    beat_t q[$];
    beat_t q0[$];

    always #5 clk = ~clk;

    buffer_lru_dump #(.WIDTH(16), .BUF_SIZE(8), .SKIP_EMPTY(1)) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .buf_array_i(arr),
        .busy_o(busy), .valid_o(valid), .ready_i(ready), .data_o(data),
        .idx_o(idx), .last_o(last), .done_o(done), .count_o(count)
    );

    buffer_lru_dump #(.WIDTH(16), .BUF_SIZE(8), .SKIP_EMPTY(0)) dut0 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start0), .buf_array_i(arr),
        .busy_o(busy0), .valid_o(valid0), .ready_i(ready), .data_o(data0),
        .idx_o(idx0), .last_o(last0), .done_o(done0), .count_o(count0)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        beat_t b;
        if (done) n_done++;
        if (valid && ready) begin
            chk("beat_expected", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
                b = q.pop_front();
                chk("beat_data", 32'(data), 32'(b.d));
                chk("beat_idx", 32'(idx), 32'(b.i));
                chk("beat_last", 32'(last), 32'(b.l));
                if (idx == 3'd2) n_acc2++;
                if (last) last_cyc = cyc;
            end
        end else if (!valid) begin
            chk("idle_zero", 32'({data, idx, last}), 0);
        end
    end

    always @(negedge clk) begin : mon0
        beat_t b;
        if (done0) n_done0++;
        if (valid0 && ready) begin
            chk("beat0_expected", 32'(q0.size() > 0), 1);
            if (q0.size() > 0) begin
                b = q0.pop_front();
                chk("beat0_data", 32'(data0), 32'(b.d));
                chk("beat0_idx", 32'(idx0), 32'(b.i));
                chk("beat0_last", 32'(last0), 32'(b.l));
            end
        end
    end

    // Expected beats: emit-able slots in index order, last flag on the final one.
    task automatic exp_dump(input logic [7:0][15:0] a, input bit skip,
                            input bit which);
        int    lastk;
        beat_t b;
        lastk = -1;
        for (int i = 0; i < 8; i++)
            if (!skip || a[i] != 16'd0) lastk = i;
        for (int i = 0; i < 8; i++) begin
            if (!skip || a[i] != 16'd0) begin
                b.d = a[i];
                b.i = 3'(i);
                b.l = (i == lastk);
                if (which) q0.push_back(b);
                else q.push_back(b);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit which);
        if (which) start0 = 1'b1;
        else start = 1'b1;
        tick();
        start  = 1'b0;
        start0 = 1'b0;
    endtask

    task automatic wait_done(input bit which, input int budget,
                             output int waited);
        waited = 0;
        while (!(which ? done0 : done) && waited < budget) begin
            tick();
            waited++;
        end
        chk(which ? "done0_seen" : "done_seen", 32'(which ? done0 : done), 1);
    endtask

    task automatic wait_idx(input logic [2:0] k, input int budget);
        int n;
        n = 0;
        while (!(valid && idx == k) && n < budget) begin
            tick();
            n++;
        end
        chk("idx_seen", 32'(valid && idx == k), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0][15:0] A, B, C;
        int               w, d0;
        A = {16'd107, 16'd106, 16'd105, 16'd112,
             16'd110, 16'd109, 16'd111, 16'd108};
        B = {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd101, 16'd100};
        C = {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd100};

        rst_n = 1'b0; start = 1'b0; start0 = 1'b0; ready = 1'b0; arr = A;
        tick(); tick();
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_data", 32'(data), 0);
        rst_n = 1'b1;
        tick();

        // 1: full array, ready always high
        ready = 1'b1; arr = A; d0 = n_done;
        exp_dump(A, 1'b1, 1'b0);
        pulse_start(1'b0);
        chk("t1_busy_n1", 32'(busy), 1);
        chk("t1_valid_n1", 32'(valid), 0);
        tick();
        chk("t1_valid_n2", 32'(valid), 1);
        chk("t1_idx_n2", 32'(idx), 0);
        wait_done(1'b0, 64, w);
        chk("t1_done_gap", 32'(cyc), 32'(last_cyc + 1));
        chk("t1_count", 32'(count), 8);
        chk("t1_sb_empty", 32'(q.size()), 0);
        tick();
        chk("t1_busy_after", 32'(busy), 0);
        chk("t1_done_once", 32'(n_done), 32'(d0 + 1));

        // 2: sparse, then all zero
        arr = B;
        exp_dump(B, 1'b1, 1'b0);
        pulse_start(1'b0);
        wait_done(1'b0, 64, w);
        chk("t2_done_gap", 32'(cyc), 32'(last_cyc + 1));
        chk("t2_count", 32'(count), 2);
        chk("t2_sb_empty", 32'(q.size()), 0);
        tick();
        arr = '0; d0 = n_done;
        pulse_start(1'b0);
        wait_done(1'b0, 64, w);
        chk("t2z_latency", 32'(w), 8);
        chk("t2z_count", 32'(count), 0);
        tick();
        chk("t2z_busy_after", 32'(busy), 0);
        chk("t2z_done_once", 32'(n_done), 32'(d0 + 1));

        // 3: backpressure on idx 2
        arr = A; n_acc2 = 0;
        exp_dump(A, 1'b1, 1'b0);
        pulse_start(1'b0);
        wait_idx(3'd2, 40);
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_valid", 32'(valid), 1);
            chk("t3_hold_data", 32'(data), 109);
            chk("t3_hold_idx", 32'(idx), 2);
            tick();
        end
        chk("t3_no_acc_yet", 32'(n_acc2), 0);
        ready = 1'b1;
        wait_done(1'b0, 64, w);
        chk("t3_acc_once", 32'(n_acc2), 1);
        chk("t3_count", 32'(count), 8);
        chk("t3_sb_empty", 32'(q.size()), 0);
        tick();

        // 4: snapshot isolation and ignored starts
        arr = A; d0 = n_done;
        exp_dump(A, 1'b1, 1'b0);
        pulse_start(1'b0);
        arr = '1;
        tick(); tick();
        pulse_start(1'b0);
        wait_done(1'b0, 64, w);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_busy_after", 32'(busy), 0);
        tick();
        chk("t4_still_idle", 32'(busy), 0);
        chk("t4_done_once", 32'(n_done), 32'(d0 + 1));
        chk("t4_count", 32'(count), 8);
        chk("t4_sb_empty", 32'(q.size()), 0);

        // 5: async reset mid-dump
        arr = A;
        exp_dump(A, 1'b1, 1'b0);
        pulse_start(1'b0);
        wait_idx(3'd3, 40);
        chk("t5_count_pre", 32'(count), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid_rst", 32'(valid), 0);
        chk("t5_busy_rst", 32'(busy), 0);
        chk("t5_count_rst", 32'(count), 0);
        chk("t5_sb_left", 32'(q.size()), 5);
        q.delete();
        tick(); tick();
        rst_n = 1'b1;
        tick();
        exp_dump(A, 1'b1, 1'b0);
        pulse_start(1'b0);
        tick();
        chk("t5_restart_valid", 32'(valid), 1);
        chk("t5_restart_idx", 32'(idx), 0);
        wait_done(1'b0, 64, w);
        chk("t5_count", 32'(count), 8);
        chk("t5_sb_empty", 32'(q.size()), 0);
        tick();

        // 6: emit every slot, zeros included
        arr = C;
        exp_dump(C, 1'b0, 1'b1);
        pulse_start(1'b1);
        wait_done(1'b1, 64, w);
        chk("t6_count", 32'(count0), 8);
        chk("t6_sb_empty", 32'(q0.size()), 0);
        chk("t6_done_pulses", 32'(n_done0), 0);
        tick();
        chk("t6_done_once", 32'(n_done0), 1);
        chk("t6_busy_after", 32'(busy0), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
